// File: rtl/pipe_pkg.sv
// pipe_pkg: shared width default and log2 helper for the stallable pipeline and its receiver
package pipe_pkg;

    localparam int PIPE_WIDTH = 100;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/pipe_rx_mem.sv
// pipe_rx_mem: DEPTH x WIDTH register array, one write port, one asynchronous read port, no reset
module pipe_rx_mem
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // storage write; contents are only meaningful behind a valid count
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_rx_skid_fifo.sv
// pipe_rx_skid_fifo: pipeline-tail receiver buffering words in a FIFO with a flop-only in_allow
module pipe_rx_skid_fifo
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        validin,
    input  logic [WIDTH-1:0]            datain,
    output logic                        in_allow,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH+1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // flags decode from the count register only, so out_ready never reaches in_allow
    always_comb begin
        in_allow  = (count != CW'(DEPTH));
        out_valid = (count != '0);
        push      = validin && in_allow;
        pop       = out_valid && out_ready;
    end

    // pointer and occupancy state; flush beats push and pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    pipe_rx_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (datain),
        .raddr (rd_ptr),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_pipe_rx_skid_fifo.sv
// tb_pipe_rx_skid_fifo: scoreboard bench for the pipeline-tail receive FIFO
module tb_pipe_rx_skid_fifo;

    localparam int W = 100;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          validin = 1'b0;
    logic [W-1:0]  datain = '0;
    logic          in_allow;
    logic          flush = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready = 1'b0;
    logic [2:0]    count;

    int vectors = 0;
    int errs = 0;
    logic [W-1:0] q [$];

    always #5 clk = ~clk;

    pipe_rx_skid_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .validin   (validin),
        .datain    (datain),
        .in_allow  (in_allow),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        validin = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (count != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", count, 0);
        chk("sb_empty", q.size(), 0);
        out_ready = 1'b0;
    endtask

    task automatic fill(input int n, input logic [W-1:0] base);
        out_ready = 1'b0;
        validin = 1'b1;
        for (int i = 0; i < n; i++) begin
            datain = base + W'(i);
            step();
        end
        validin = 1'b0;
    endtask

    // scoreboard: model occupancy from handshakes, check flags, head word and order
    always @(negedge clk) begin
        bit m_push;
        bit m_pop;
        if (!rst) begin
            q.delete();
            chk("rst_in_allow", in_allow, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_count", count, 0);
        end else begin
            chk("count", count, q.size());
            chk("in_allow", in_allow, q.size() != D);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) chk("head", out_data, q[0]);
            m_pop  = (q.size() != 0) && out_ready;
            m_push = validin && (q.size() != D);
            if (q.size() > D) chk("overflow", q.size(), D);
            if (flush) q.delete();
            else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back(datain);
            end
        end
    end

    initial begin
        int acc;
        int n;
        void'($urandom(32'd1234));
        validin = 1'b1;
        datain = W'(32'h11);
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("first_push", count, 1);
        drain();

        datain = W'(8'hA1);
        validin = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("fill_count", count, i);
            datain = W'(8'hA1) + W'(i);
        end
        chk("full_in_allow", in_allow, 0);
        step();
        chk("a5_held", count, 4);
        out_ready = 1'b1;
        step();
        chk("drop_to_3", count, 3);
        chk("allow_back", in_allow, 1);
        step();
        chk("a5_taken", count, 3);
        drain();

        validin = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            datain = W'(i);
            step();
            chk("stream_count", count, 1);
            chk("stream_allow", in_allow, 1);
            chk("stream_data", out_data, i);
        end
        validin = 1'b0;
        step();
        chk("stream_empty", count, 0);

        acc = 0;
        n = 0;
        validin = 1'b1;
        while (acc < 3 * D && n < 200) begin
            datain = W'(32'h100) + W'(acc);
            out_ready = 1'($urandom_range(0, 1));
            if (in_allow) acc++;
            step();
            n++;
        end
        chk("wrap_done", acc, 3 * D);
        drain();

        fill(4, W'(8'hC0));
        validin = 1'b1;
        datain = W'(8'hC4);
        out_ready = 1'b1;
        chk("fullpop_allow_now", in_allow, 0);
        step();
        chk("fullpop_count", count, 3);
        chk("fullpop_allow_next", in_allow, 1);
        drain();

        fill(3, W'(8'hD0));
        validin = 1'b1;
        datain = W'(8'hD3);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        validin = 1'b0;
        out_ready = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_allow", in_allow, 1);
        validin = 1'b1;
        datain = W'(8'h55);
        step();
        validin = 1'b0;
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_data", out_data, W'(8'h55));
        drain();

        fill(2, W'(8'hE0));
        #2;
        rst = 1'b0;
        #1;
        chk("async_allow", in_allow, 1);
        chk("async_valid", out_valid, 0);
        chk("async_count", count, 0);
        step();
        rst = 1'b1;
        step();
        chk("sb_final", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
